loss_grad: RTL
==============

LOSS_GRAD -- requirements
Module: loss_grad

Interface
Parameters:
REQ-001 SHALL have parameter IL, default 4: integer bits of signed fixed-point data.
REQ-002 SHALL have parameter FL, default 16: fractional bits; data width W = IL+FL.
REQ-003 SHALL have parameter size, default 16: vector length; width = $clog2(size).
Ports:
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port model  input  1  gradient select: 1 = MSE-style 2*(yHat-y), 0 = MAE-style sign(yHat-y).
REQ-007 SHALL have port yHat  input  signed W x size  predictions.
REQ-008 SHALL have port y  input  signed W x size  targets.
REQ-009 SHALL have port num  input  width  count of valid elements; indices >= num are invalid.
REQ-010 SHALL have port input_ready  input  1  producer request to start a job.
REQ-011 SHALL have port output_taken  input  1  consumer acknowledge of the result.
REQ-012 SHALL have port state  output  2  FSM state.
REQ-013 SHALL have port grad  output  signed W x size  per-element gradient dL/dyHat.
REQ-014 SHALL have port out_valid  output  1  high exactly while state is DONE.

Function
REQ-015 SHALL implement FSM IDLE=2'b00, COMPUTE=2'b01, DONE=2'b10; 2'b11 is illegal and SHALL recover to IDLE on the next edge.
REQ-016 SHALL, in IDLE with input_ready=1, latch yHat, y, num and model on edge E0, clear index to 0 and enter COMPUTE.
REQ-017 SHALL, in COMPUTE, process one element per cycle: grad[i] written on edge E(i+1), for i = 0..size-1.
REQ-018 SHALL enter DONE with out_valid=1 on edge E16, i.e. the edge that writes grad[size-1].
REQ-019 SHALL form diff = latched yHat[i] - y[i] at W+1 bits, with no overflow.
REQ-020 SHALL compute grad[i] for model=1 as 2*diff at W+2 bits, then apply width reduction per REQ-029/REQ-030.
REQ-021 SHALL compute grad[i] for model=0 as +2^FL if diff>0, -2^FL if diff<0, and 0 if diff=0.
REQ-022 SHALL write grad[i]=0 for every i >= latched num; num=0 yields an all-zero vector.
REQ-023 SHALL hold grad and state in DONE until output_taken=1, then return to IDLE on that edge.
REQ-024 SHALL ignore input_ready in COMPUTE and DONE; latched operands are unaffected by input changes.
REQ-025 SHALL ignore output_taken outside DONE.
REQ-026 SHALL, when input_ready and output_taken are both 1 in DONE, go to IDLE without capturing; input_ready is sampled again in IDLE on the following edge.
REQ-027 SHALL keep grad unchanged in IDLE, holding the last result.

Reset
REQ-028 SHALL, while reset=0 and without waiting for a clock edge, force state=IDLE, out_valid=0, index=0, all grad=0 and all latched operands=0; an in-flight COMPUTE is abandoned.

Configuration
REQ-029 SHALL, with LOSS_GRAD_SAT_EN defined, saturate model=1 results to [-2^(W-1), 2^(W-1)-1].
REQ-030 SHALL, without LOSS_GRAD_SAT_EN defined, truncate model=1 results to the low W bits (two's-complement wrap); model=0 is unaffected by the macro.

Verification
REQ-031 SHALL cover: model=1, num=10, yHat[j]=j, y[j]=3 -> grad[0]=-6, grad[3]=0, grad[9]=12, grad[10..15]=0; out_valid high after E16.
REQ-032 SHALL cover: model=0, num=5, yHat[k]=2k, y[k]=5 -> grad[0..2]=-65536, grad[3..4]=65536, grad[5..15]=0.
REQ-033 SHALL cover: model=1, num=1, yHat[0]=300000, y[0]=-300000 -> grad[0]=524287 with LOSS_GRAD_SAT_EN, 151424 without.
REQ-034 SHALL cover: reset driven low between E5 and E6 -> immediately state=00, out_valid=0, grad all 0; a new job after release completes normally.
REQ-035 SHALL cover: in DONE, input_ready=1 and output_taken=1 together -> IDLE with no capture; input_ready held one more cycle -> capture, then DONE 16 edges later.
REQ-036 SHALL cover: input_ready pulsed in COMPUTE and output_taken pulsed in IDLE -> no effect on state, index or grad.

Source files
------------

// File: rtl/loss_grad.sv
// loss_grad -- per-element loss gradient dL/dyHat over a fixed-length vector.
//
// A job is captured from the producer in IDLE. The block then walks the
// latched vectors one element per clock and writes grad[i]. It then holds
// the result in DONE until the consumer acknowledges it.
//
//   model = 1 : grad[i] = 2*(yHat[i]-y[i]), reduced to W bits
//   model = 0 : grad[i] = sign(yHat[i]-y[i]) scaled to +/-1.0 (2^FL)
//   i >= num  : grad[i] = 0
//
// Build option: define LOSS_GRAD_SAT_EN to saturate model=1 results to the
// W-bit signed range. Without it, model=1 results wrap to the low W bits.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   model        in   gradient select (1 = MSE-style, 0 = MAE-style)
//   yHat, y      in   signed W-bit predictions / targets, size entries
//   num          in   count of valid elements
//   input_ready  in   producer start request (sampled in IDLE only)
//   output_taken in   consumer acknowledge (sampled in DONE only)
//   state        out  FSM state
//   grad         out  signed W-bit gradients, size entries
//   out_valid    out  high exactly while in DONE
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for input_ready; grad holds last result
// COMPUTE | writing grad[idx], one element per clock
// DONE    | result valid; waiting for output_taken
// 2'b11   | illegal; returns to IDLE on the next edge

module loss_grad #(
  parameter int IL   = 4,
  parameter int FL   = 16,
  parameter int size = 16,
  localparam int W   = IL + FL,
  localparam int CW  = $clog2(size)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                model,
  input  logic signed [W-1:0] yHat [size],
  input  logic signed [W-1:0] y    [size],
  input  logic [CW-1:0]       num,
  input  logic                input_ready,
  input  logic                output_taken,
  output logic [1:0]          state,
  output logic signed [W-1:0] grad [size],
  output logic                out_valid
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam logic signed [W-1:0] POS_ONE = W'(64'd1 << FL);
  localparam logic signed [W-1:0] NEG_ONE = -POS_ONE;
  localparam logic signed [W-1:0] SMAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0]       LAST    = CW'(size - 1);

  state_t              st;
  logic [CW-1:0]       idx;
  logic [CW-1:0]       num_q;
  logic                model_q;
  logic signed [W-1:0] yhat_q [size];
  logic signed [W-1:0] y_q    [size];

  logic signed [W:0]   diff;
  logic signed [W+1:0] dbl;
  logic signed [W-1:0] g_mse;
  logic signed [W-1:0] g_mae;
  logic signed [W-1:0] g_next;

  assign state = st;

  // Datapath for the element currently selected by idx.
  always_comb begin
    diff  = {yhat_q[idx][W-1], yhat_q[idx]} - {y_q[idx][W-1], y_q[idx]};
    dbl   = {diff, 1'b0};
    g_mse = dbl[W-1:0];
`ifdef LOSS_GRAD_SAT_EN
    // dbl fits in W bits only when its top three bits agree.
    if (!((dbl[W+1:W-1] == 3'b000) || (dbl[W+1:W-1] == 3'b111)))
      g_mse = dbl[W+1] ? SMIN : SMAX;
`endif
    if (diff == '0)
      g_mae = '0;
    else if (diff[W])
      g_mae = NEG_ONE;
    else
      g_mae = POS_ONE;
    if (idx >= num_q)
      g_next = '0;
    else if (model_q)
      g_next = g_mse;
    else
      g_next = g_mae;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= IDLE;
      out_valid <= 1'b0;
      idx       <= '0;
      num_q     <= '0;
      model_q   <= 1'b0;
      for (int i = 0; i < size; i++) begin
        yhat_q[i] <= '0;
        y_q[i]    <= '0;
        grad[i]   <= '0;
      end
    end else begin
      case (st)
        IDLE: begin
          if (input_ready) begin
            for (int i = 0; i < size; i++) begin
              yhat_q[i] <= yHat[i];
              y_q[i]    <= y[i];
            end
            num_q   <= num;
            model_q <= model;
            idx     <= '0;
            st      <= COMPUTE;
          end
        end
        COMPUTE: begin
          grad[idx] <= g_next;
          if (idx == LAST) begin
            st        <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + CW'(1);
          end
        end
        DONE: begin
          // input_ready in the same cycle is deliberately not captured; it
          // is sampled again once back in IDLE.
          if (output_taken) begin
            st        <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
